fsm_count_checker: RTL and testbench
====================================

// Module: fsm_count_checker
// PURPOSE
//   Receive-side monitor for the 3-bit FSM counter stream (en, num).
//   Samples the enable and count value each clock and predicts the next value (+1 when enabled, hold otherwise).
//   Reports lock, mismatch pulses, wrap events and saturating statistics.
//   Sits beside the counter in the design and in benches as a self-checking sink.
// PARAMETERS
//   W        3   count width; the wrap point is 2**W-1 -> 0
//   LOCK_N   4   consecutive matching samples needed to leave FAULT
//   CNT_W    8   width of err_cnt and wrap_cnt, both saturating
// PORTS
//   clk       in   1      rising-edge clock, the only clock
//   reset     in   1      synchronous, active-low reset
//   en        in   1      count enable, the same signal that drives the counter
//   num       in   W      counter output under check
//   locked    out  1      1 while in LOCKED
//   err       out  1      one-cycle pulse per mismatching sample
//   wrap      out  1      one-cycle pulse on a checked 2**W-1 -> 0 step
//   err_cnt   out  CNT_W  number of mismatches, saturates at all-ones
//   wrap_cnt  out  CNT_W  number of wraps, saturates at all-ones
// BEHAVIOUR
//   - Reset: when reset==0 at a rising edge, all outputs go to 0.
//     prev_num and prev_en go to 0, fail_run goes to 0, state goes to SYNC.
//   - Every edge with reset==1: register prev_num<=num and prev_en<=en.
//   - Expected value: exp = prev_en ? prev_num+1 (mod 2**W) : prev_num.
//   - match = (num==exp).
//   - States:
//     SYNC   : first edge after reset release only captures, no check.
//              Next state is LOCKED, so locked is 1 from the 2nd edge.
//     LOCKED : on a mismatch, go to FAULT. err pulses 1 cycle and err_cnt++.
//     FAULT  : each match increments run; each mismatch clears run, pulses err and bumps err_cnt.
//              When run reaches LOCK_N-1 and the current sample matches, go to LOCKED.
//   - Output latency: all outputs are registered, updated at the same edge that samples num.
//     err/wrap are visible in the cycle after the offending num was present.
//   - wrap: pulses only in LOCKED or FAULT, when prev_en==1, prev_num==2**W-1, num==0 and match.
//     Increments wrap_cnt.
//   - Mismatch and wrap never coincide (a wrap requires a match).
//   - Saturation: counters hold at all-ones and never roll over.
//   - en toggling every cycle is legal; the prediction always uses the prior-cycle en.
//   - A held value (en==0) counts as a match, not a fault.
//   - Reset mid-operation: the state returns to SYNC at that edge and the counters clear.
//     No err is raised for the discontinuity.
// STRUCTURE
//   - Shared package: state encoding localparams ST_SYNC=2'd0, ST_LOCKED=2'd1, ST_FAULT=2'd2.
//     The default W=3 count width also goes in the package, for reuse by the counter.
//   - One sub-module, sat_counter (parameter CNT_W; ports clk, reset, inc, q), used twice.
//   - The state register, prediction logic and run counter stay in the top module.
// TESTING
//   1. reset=0 for 2 cycles, then reset=1, en=1, driven by a real counter for 20 cycles:
//      locked=1 from the 2nd edge, err_cnt=0, wrap=1 on each 7->0 step, wrap_cnt=2.
//   2. en=0 with num held at 5 for 10 cycles: locked stays 1, err stays 0, no wraps.
//   3. In lock with en=1, num 2,3 then a forced 6:
//      err pulses once, locked=0, err_cnt=1.
//      Then 4 correct steps are needed for locked=1: 3 are not enough.
//   4. In FAULT, a second mismatch after 2 good steps: err_cnt=2.
//      The run restarts, and LOCK_N=4 fresh matches are required.
//   5. CNT_W=2, 5 forced mismatches: err_cnt saturates at 3.
//   6. reset=0 for 1 cycle mid-count at num=4: outputs are 0 on the next edge and the state is SYNC.
//      No err on the first sample after release; locked=1 one edge later.

Source files
------------

// File: rtl/fsm_count_checker_pkg.sv
// Shared definitions for the 3-bit counter stream checker and its companion counter.
package fsm_count_checker_pkg;

    localparam int unsigned DEF_W = 3;

    localparam logic [1:0] ST_SYNC   = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

endpackage

// File: rtl/fsm_count_checker_sat_counter.sv
// Event counter that holds at all-ones instead of rolling over.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (inc && (q != {CNT_W{1'b1}})) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fsm_count_checker.sv
// Receive-side monitor for an (en, num) counter stream: predicts each sample
// from the previous one, tracks lock, and counts mismatches and wraps.
module fsm_count_checker
    import fsm_count_checker_pkg::*;
#(
    parameter int unsigned W      = DEF_W,
    parameter int unsigned LOCK_N = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [W-1:0]     num,
    output logic             locked,
    output logic             err,
    output logic             wrap,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] wrap_cnt
);

    localparam int unsigned RUN_W = $clog2(LOCK_N + 1);

    logic [1:0]       state;
    logic [1:0]       nxt;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_nxt;
    logic [W-1:0]     prev_num;
    logic             prev_en;
    logic [W-1:0]     exp_num;
    logic             match;
    logic             err_nxt;
    logic             wrap_nxt;

    // State, history and registered outputs; locked only rises once a real check has passed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_SYNC;
            run      <= '0;
            prev_num <= '0;
            prev_en  <= 1'b0;
            locked   <= 1'b0;
            err      <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            state    <= nxt;
            run      <= run_nxt;
            prev_num <= num;
            prev_en  <= en;
            locked   <= (state != ST_SYNC) && (nxt == ST_LOCKED);
            err      <= err_nxt;
            wrap     <= wrap_nxt;
        end
    end

    // Prediction, next state and output events.
    always_comb begin
        nxt      = state;
        run_nxt  = run;
        err_nxt  = 1'b0;
        wrap_nxt = 1'b0;
        exp_num  = prev_en ? (prev_num + W'(1)) : prev_num;
        match    = (num == exp_num);

        case (state)
            ST_SYNC: begin
                nxt     = ST_LOCKED;
                run_nxt = '0;
            end
            ST_LOCKED: begin
                if (!match) begin
                    nxt     = ST_FAULT;
                    run_nxt = '0;
                    err_nxt = 1'b1;
                end
            end
            ST_FAULT: begin
                if (!match) begin
                    run_nxt = '0;
                    err_nxt = 1'b1;
                end else if (run == RUN_W'(LOCK_N - 1)) begin
                    nxt     = ST_LOCKED;
                    run_nxt = '0;
                end else begin
                    run_nxt = run + RUN_W'(1);
                end
            end
            default: begin
                nxt     = ST_SYNC;
                run_nxt = '0;
            end
        endcase

        wrap_nxt = (state != ST_SYNC) && prev_en && (prev_num == {W{1'b1}})
                   && (num == '0) && match;
    end

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_nxt),
        .q     (err_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wrap_nxt),
        .q     (wrap_cnt)
    );

endmodule

// File: tb/tb_fsm_count_checker.sv
// Directed bench for fsm_count_checker against a sample-history model, with a narrow-counter twin.
module tb_fsm_count_checker;

    localparam int unsigned W = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic [W-1:0] num = '0;

    logic         locked, err, wrap;
    logic [7:0]   err_cnt, wrap_cnt;
    logic         locked2, err2, wrap2;
    logic [1:0]   err_cnt2, wrap_cnt2;

    int total = 0;
    int bad   = 0;

    // model state
    int  m_since;
    bit  m_inlock;
    int  m_good;
    int  m_pn;
    bit  m_pe;
    bit  m_locked, m_err, m_wrap;
    int  m_errs, m_wraps, m_errs2, m_wraps2;
    int  cnt;

    always #5 clk = ~clk;

    fsm_count_checker dut (
        .clk(clk), .reset(reset), .en(en), .num(num),
        .locked(locked), .err(err), .wrap(wrap),
        .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
    );

    fsm_count_checker #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .num(num),
        .locked(locked2), .err(err2), .wrap(wrap2),
        .err_cnt(err_cnt2), .wrap_cnt(wrap_cnt2)
    );

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Predict outputs after one clock edge from the sample history.
    task automatic model_edge(input bit r, input bit e, input int n);
        int  expn;
        bit  ok;
        if (!r) begin
            m_since = 0; m_inlock = 0; m_good = 0; m_pn = 0; m_pe = 0;
            m_locked = 0; m_err = 0; m_wrap = 0;
            m_errs = 0; m_wraps = 0; m_errs2 = 0; m_wraps2 = 0;
            return;
        end
        if (m_since == 0) begin
            m_inlock = 1; m_good = 0;
            m_locked = 0; m_err = 0; m_wrap = 0;
        end else begin
            expn = m_pe ? (m_pn + 1) % 8 : m_pn;
            ok   = (n == expn);
            if (m_inlock) begin
                if (!ok) begin m_inlock = 0; m_good = 0; end
            end else if (ok) begin
                m_good++;
                if (m_good == 4) m_inlock = 1;
            end else begin
                m_good = 0;
            end
            m_err    = !ok;
            m_wrap   = ok && m_pe && (m_pn == 7) && (n == 0);
            m_locked = m_inlock;
            if (m_err) begin
                if (m_errs < 255) m_errs++;
                if (m_errs2 < 3) m_errs2++;
            end
            if (m_wrap) begin
                if (m_wraps < 255) m_wraps++;
                if (m_wraps2 < 3) m_wraps2++;
            end
        end
        m_since++;
        m_pn = n;
        m_pe = e;
    endtask

    task automatic compare_all();
        chk("locked",    int'(locked),    int'(m_locked));
        chk("err",       int'(err),       int'(m_err));
        chk("wrap",      int'(wrap),      int'(m_wrap));
        chk("err_cnt",   int'(err_cnt),   m_errs);
        chk("wrap_cnt",  int'(wrap_cnt),  m_wraps);
        chk("locked2",   int'(locked2),   int'(m_locked));
        chk("err_cnt2",  int'(err_cnt2),  m_errs2);
        chk("wrap_cnt2", int'(wrap_cnt2), m_wraps2);
    endtask

    task automatic drive(input bit r, input bit e, input int n);
        reset = r;
        en    = e;
        num   = W'(n);
        @(posedge clk);
        model_edge(r, e, n);
        @(negedge clk);
        #1;
        compare_all();
    endtask

    task automatic count(input bit e);
        drive(1'b1, e, cnt);
        if (e) cnt = (cnt + 1) % 8;
    endtask

    task automatic force_bad();
        int n;
        n = (cnt + 3) % 8;
        drive(1'b1, 1'b1, n);
        cnt = (n + 1) % 8;
    endtask

    initial begin
        m_since = 0; m_inlock = 0; m_good = 0; m_pn = 0; m_pe = 0;
        m_locked = 0; m_err = 0; m_wrap = 0;
        m_errs = 0; m_wraps = 0; m_errs2 = 0; m_wraps2 = 0;
        cnt = 0;

        // 1: reset, then a real counter for 20 cycles
        drive(1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        count(1'b1);
        chk("sync_locked", int'(locked), 0);
        count(1'b1);
        chk("edge2_locked", int'(locked), 1);
        for (int i = 0; i < 18; i++) count(1'b1);
        chk("t1_wrap_cnt", int'(wrap_cnt), 2);
        chk("t1_err_cnt", int'(err_cnt), 0);
        chk("t1_locked", int'(locked), 1);

        // 2: hold at 5 with en=0
        count(1'b1);
        for (int i = 0; i < 10; i++) count(1'b0);
        chk("t2_num_held", int'(num), 5);
        chk("t2_locked", int'(locked), 1);
        chk("t2_err_cnt", int'(err_cnt), 0);
        chk("t2_wrap_cnt", int'(wrap_cnt), 2);

        // 3: count to 3, force 6, then relock after four good steps
        for (int i = 0; i < 7; i++) count(1'b1);
        drive(1'b1, 1'b1, 6);
        cnt = 7;
        chk("t3_err", int'(err), 1);
        chk("t3_locked", int'(locked), 0);
        chk("t3_err_cnt", int'(err_cnt), 1);
        for (int i = 0; i < 3; i++) count(1'b1);
        chk("t3_three_not_enough", int'(locked), 0);
        count(1'b1);
        chk("t3_relock", int'(locked), 1);
        chk("t3_wrap_cnt", int'(wrap_cnt), 4);

        // 4: second mismatch inside FAULT restarts the run
        force_bad();
        count(1'b1);
        count(1'b1);
        force_bad();
        chk("t4_err_cnt", int'(err_cnt), 3);
        for (int i = 0; i < 3; i++) count(1'b1);
        chk("t4_still_fault", int'(locked), 0);
        count(1'b1);
        chk("t4_relock", int'(locked), 1);
        chk("t4_wrap_cnt", int'(wrap_cnt), 6);

        // 5: two more mismatches, narrow counter saturates at 3
        force_bad();
        force_bad();
        chk("t5_err_cnt", int'(err_cnt), 5);
        chk("t5_err_cnt2_sat", int'(err_cnt2), 3);
        chk("t5_wrap_cnt2_sat", int'(wrap_cnt2), 3);
        for (int i = 0; i < 4; i++) count(1'b1);
        chk("t5_relock", int'(locked), 1);

        // 6: reset mid-count after num=4, discontinuous restart
        drive(1'b0, 1'b1, 5);
        chk("t6_locked", int'(locked), 0);
        chk("t6_err_cnt", int'(err_cnt), 0);
        chk("t6_wrap_cnt", int'(wrap_cnt), 0);
        drive(1'b1, 1'b1, 2);
        chk("t6_no_err", int'(err), 0);
        chk("t6_sync_locked", int'(locked), 0);
        drive(1'b1, 1'b1, 3);
        chk("t6_locked_after", int'(locked), 1);
        chk("t6_err_after", int'(err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
